// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer
//   Draws one ROM-backed, palette-indexed sprite inside a fixed screen rectangle, scaled by
//   an integer power of two, composited over a background RGB stream. Optional colour-key
//   transparency; a trigger pulse inverts the sprite colours for FLASH_FRAMES frames.
//   Three-stage pipeline: address (stage 1), ROM read (stage 2), palette/composite (stage 3).
//
// Ports
//   vga_clk, reset_n        pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank     current pixel position and active-video flag
//   bg_red/green/blue       background colour, aligned with DrawX/DrawY
//   trigger                 one-cycle pulse, (re)starts the flash
//   pal_we/waddr/wdata      palette write port, {r,g,b} 4 bits each
//   rom_address, rom_q      external synchronous ROM (one cycle read latency)
//   red/green/blue          registered output colour
//   sprite_hit              output pixel comes from an opaque sprite texel
//   flash_active            flash counter non-zero

module sprite_layer_renderer #(
   parameter int unsigned X0              = 0,
   parameter int unsigned Y0              = 297,
   parameter int unsigned SPR_W           = 35,
   parameter int unsigned SPR_H           = 58,
   parameter int unsigned SCALE_SHIFT     = 0,
   parameter int unsigned ADDR_W          = 11,
   parameter int unsigned IDX_W           = 1,
   parameter int unsigned FLASH_FRAMES    = 8,
   parameter bit          TRANSPARENT_EN  = 1'b1,
   parameter int unsigned TRANSPARENT_IDX = 0
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [3:0]        bg_red,
   input  logic [3:0]        bg_green,
   input  logic [3:0]        bg_blue,
   input  logic              trigger,
   input  logic              pal_we,
   input  logic [IDX_W-1:0]  pal_waddr,
   input  logic [11:0]       pal_wdata,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              sprite_hit,
   output logic              flash_active
);

   // Coordinate arithmetic width: wide enough for row * SPR_W before truncation.
   localparam int unsigned CW    = ADDR_W + 12;
   localparam int unsigned PAL_N = 2 ** IDX_W;
   localparam int unsigned CNT_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

   localparam logic [CW-1:0]    XLo      = CW'(X0);
   localparam logic [CW-1:0]    YLo      = CW'(Y0);
   localparam logic [CW-1:0]    XSpan    = CW'(SPR_W << SCALE_SHIFT);
   localparam logic [CW-1:0]    YSpan    = CW'(SPR_H << SCALE_SHIFT);
   localparam logic [CW-1:0]    SprW     = CW'(SPR_W);
   localparam logic [CNT_W-1:0] FlashLd  = CNT_W'(FLASH_FRAMES);
   localparam logic [IDX_W-1:0] KeyIdx   = IDX_W'(TRANSPARENT_IDX);

   // ---------------- Stage 1: box test and texel address ----------------
   logic [CW:0]       x_diff, y_diff;
   logic [CW-1:0]     addr_full;
   logic              in_box_d;
   logic [ADDR_W-1:0] rom_addr_d;

   always_comb begin
      // Extra top bit flags a negative offset, so pixels left/above the box never wrap.
      x_diff     = {1'b0, CW'(DrawX)} - {1'b0, XLo};
      y_diff     = {1'b0, CW'(DrawY)} - {1'b0, YLo};
      in_box_d   = !x_diff[CW] && (x_diff[CW-1:0] < XSpan) &&
                   !y_diff[CW] && (y_diff[CW-1:0] < YSpan);
      addr_full  = (x_diff[CW-1:0] >> SCALE_SHIFT) + (y_diff[CW-1:0] >> SCALE_SHIFT) * SprW;
      rom_addr_d = in_box_d ? addr_full[ADDR_W-1:0] : '0;
   end

   logic              in_box_q, blank_q;
   logic [11:0]       bg_q;
   logic [ADDR_W-1:0] rom_addr_q;

   // ---------------- Stage 2: wait for ROM, keep side-band aligned ----------------
   logic              in_box_q2, blank_q2;
   logic [11:0]       bg_q2;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         in_box_q   <= 1'b0;
         blank_q    <= 1'b0;
         bg_q       <= '0;
         rom_addr_q <= '0;
         in_box_q2  <= 1'b0;
         blank_q2   <= 1'b0;
         bg_q2      <= '0;
      end else begin
         in_box_q   <= in_box_d;
         blank_q    <= blank;
         bg_q       <= {bg_red, bg_green, bg_blue};
         rom_addr_q <= rom_addr_d;
         in_box_q2  <= in_box_q;
         blank_q2   <= blank_q;
         bg_q2      <= bg_q;
      end
   end

   assign rom_address = rom_addr_q;

   // ---------------- Palette register file ----------------
   logic [11:0] pal_q [PAL_N];

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PAL_N; i++) begin
            pal_q[i] <= '0;
         end
      end else if (pal_we) begin
         pal_q[pal_waddr] <= pal_wdata;
      end
   end

   // ---------------- Flash counter ----------------
   logic             origin, origin_q, frame_start;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             flash_q;

   always_comb begin
      origin      = (DrawX == 10'd0) && (DrawY == 10'd0);
      // Edge-detect so a position held at (0,0) counts as a single frame.
      frame_start = origin && !origin_q;
      cnt_d       = cnt_q;
      if (trigger) begin
         cnt_d = FlashLd;
      end else if (frame_start && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         origin_q <= 1'b0;
         cnt_q    <= '0;
         flash_q  <= 1'b0;
      end else begin
         origin_q <= origin;
         cnt_q    <= cnt_d;
         flash_q  <= (cnt_d != '0);
      end
   end

   assign flash_active = flash_q;

   // ---------------- Stage 3: palette lookup and composite ----------------
   logic [11:0] colour, rgb_d, rgb_q;
   logic        opaque, hit_d, hit_q;

   always_comb begin
      colour = pal_q[rom_q];
      if (flash_q) begin
         colour = ~colour;
      end
      opaque = in_box_q2 && !(TRANSPARENT_EN && (rom_q == KeyIdx));
      rgb_d  = '0;
      hit_d  = 1'b0;
      if (!blank_q2) begin
         rgb_d = '0;
         hit_d = 1'b0;
      end else if (opaque) begin
         rgb_d = colour;
         hit_d = 1'b1;
      end else begin
         rgb_d = bg_q2;
         hit_d = 1'b0;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q <= '0;
         hit_q <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hit_q <= hit_d;
      end
   end

   assign red        = rgb_q[11:8];
   assign green      = rgb_q[7:4];
   assign blue       = rgb_q[3:0];
   assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
module tb_sprite_layer_renderer;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY;
   logic        blank;
   logic [3:0]  bg_red, bg_green, bg_blue;
   logic        trigger;
   logic        pal_we;
   logic [0:0]  pal_waddr;
   logic [11:0] pal_wdata;
   logic [10:0] rom_address, s1_rom_address;
   logic [0:0]  rom_q, s1_rom_q;
   logic [3:0]  red, green, blue, s1_red, s1_green, s1_blue;
   logic        sprite_hit, flash_active, s1_hit, s1_flash;

   always #5 vga_clk = ~vga_clk;

   sprite_layer_renderer #(.FLASH_FRAMES(2)) u_dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue), .trigger(trigger),
      .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
      .rom_address(rom_address), .rom_q(rom_q), .red(red), .green(green), .blue(blue),
      .sprite_hit(sprite_hit), .flash_active(flash_active)
   );

   sprite_layer_renderer #(.FLASH_FRAMES(2), .SCALE_SHIFT(1)) u_dut_s1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue), .trigger(trigger),
      .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
      .rom_address(s1_rom_address), .rom_q(s1_rom_q), .red(s1_red), .green(s1_green),
      .blue(s1_blue), .sprite_hit(s1_hit), .flash_active(s1_flash)
   );

   // Synchronous ROM models: texel index is 0 on every fifth address.
   logic romimg [2048];
   always @(posedge vga_clk) begin
      rom_q    <= romimg[rom_address];
      s1_rom_q <= romimg[s1_rom_address];
   end

   typedef struct {
      bit          inbox;
      bit          blank;
      int          idx;
      logic [11:0] bg;
   } pix_t;

   pix_t        sb [$];
   logic [11:0] m_pal [2];
   int          m_cnt;
   bit          m_prev_org;
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pix_t z;
      z.inbox = 1'b0; z.blank = 1'b0; z.idx = 0; z.bg = '0;
      sb.delete();
      sb.push_back(z);
      sb.push_back(z);
      m_pal[0] = '0;
      m_pal[1] = '0;
      m_cnt = 0;
      m_prev_org = 1'b0;
   endtask

   // One pixel per call: drive, predict, clock, compare.
   task automatic drive(input int x, input int y, input bit bl, input logic [11:0] bg);
      pix_t        d, e;
      int          addr;
      bit          org, fs;
      logic [11:0] c, exp_rgb;
      bit          exp_hit;
      DrawX = 10'(x); DrawY = 10'(y); blank = bl;
      {bg_red, bg_green, bg_blue} = bg;
      d.inbox = (x < 35) && (y >= 297) && (y < 297 + 58);
      addr    = d.inbox ? x + (y - 297) * 35 : 0;
      d.idx   = int'(romimg[addr]);
      d.blank = bl;
      d.bg    = bg;
      sb.push_back(d);
      exp_rgb = '0;
      exp_hit = 1'b0;
      if (sb.size() != 3) begin
         check("sb_depth", 32'(sb.size()), 32'd3);
      end else begin
         e = sb.pop_front();
         c = m_pal[e.idx];
         if (m_cnt != 0) c = ~c;
         if (!e.blank) begin
            exp_rgb = '0;
         end else if (e.inbox && e.idx != 0) begin
            exp_rgb = c;
            exp_hit = 1'b1;
         end else begin
            exp_rgb = e.bg;
         end
      end
      // Model state change at this edge (palette read above used the old value).
      if (pal_we) m_pal[pal_waddr] = pal_wdata;
      org = (x == 0) && (y == 0);
      fs  = org && !m_prev_org;
      if (trigger) m_cnt = 2;
      else if (fs && m_cnt != 0) m_cnt = m_cnt - 1;
      m_prev_org = org;
      @(posedge vga_clk);
      #1;
      check("rom_address", 32'(rom_address), 32'(addr));
      check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
      check("sprite_hit", 32'(sprite_hit), 32'(exp_hit));
      check("flash_active", 32'(flash_active), 32'(m_cnt != 0));
      trigger = 1'b0;
      pal_we  = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < 2048; a++) romimg[a] = (a % 5) != 0;
      reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
      {bg_red, bg_green, bg_blue} = '0;
      trigger = 1'b0; pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
      model_reset();
      #3;
      check("reset_rgb", 32'({red, green, blue}), 32'h0);
      check("reset_hit", 32'(sprite_hit), 32'h0);
      check("reset_flash", 32'(flash_active), 32'h0);
      check("reset_addr", 32'(rom_address), 32'h0);
      #9 reset_n = 1'b1;

      // Palette[1] = F80, then basic opaque texel.
      pal_we = 1'b1; pal_waddr = 1'b1; pal_wdata = 12'hF80;
      drive(40, 10, 1, 12'h000);
      drive(3, 299, 1, 12'h000);
      check("addr_73", 32'(rom_address), 32'd73);
      drive(40, 10, 1, 12'h000);
      drive(40, 10, 1, 12'h000);
      check("rgb_f80", 32'({red, green, blue}), 32'hF80);
      check("hit_f80", 32'(sprite_hit), 32'h1);

      // Colour key and blanking.
      drive(5, 297, 1, 12'h123);
      drive(5, 297, 0, 12'h123);
      drive(40, 10, 1, 12'h000);
      check("key_bg", 32'({red, green, blue}), 32'h123);
      drive(40, 10, 1, 12'h000);
      check("blank_rgb", 32'({red, green, blue}), 32'h0);

      // Scaled instance: (7,301) -> 73; x=70 is just outside the box.
      drive(7, 301, 1, 12'h000);
      check("s1_addr_73", 32'(s1_rom_address), 32'd73);
      drive(70, 301, 1, 12'h456);
      check("s1_addr_out", 32'(s1_rom_address), 32'd0);
      drive(40, 10, 1, 12'h000);
      drive(40, 10, 1, 12'h000);
      check("s1_out_rgb", 32'({s1_red, s1_green, s1_blue}), 32'h456);
      check("s1_out_hit", 32'(s1_hit), 32'h0);

      // Flash: inverted colour, then decay over two frame starts.
      trigger = 1'b1;
      drive(11, 300, 1, 12'h000);
      check("flash_on", 32'(flash_active), 32'h1);
      drive(3, 299, 1, 12'h000);
      drive(3, 299, 1, 12'h000);
      drive(40, 10, 1, 12'h000);
      check("flash_rgb", 32'({red, green, blue}), 32'h07F);
      drive(0, 0, 1, 12'h000);
      drive(0, 0, 1, 12'h000);
      drive(1, 0, 1, 12'h000);
      check("flash_one_left", 32'(flash_active), 32'h1);
      drive(0, 0, 1, 12'h000);
      check("flash_off", 32'(flash_active), 32'h0);

      // Trigger coincident with frame start: load wins.
      drive(5, 5, 1, 12'h000);
      trigger = 1'b1;
      drive(0, 0, 1, 12'h000);
      drive(1, 0, 1, 12'h000);
      drive(0, 0, 1, 12'h000);
      check("coinc_still_on", 32'(flash_active), 32'h1);
      drive(2, 0, 1, 12'h000);
      drive(0, 0, 1, 12'h000);
      check("coinc_off", 32'(flash_active), 32'h0);

      // Palette write while streaming opaque texels.
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            pal_we = 1'b1; pal_waddr = 1'b1; pal_wdata = 12'hABC;
         end
         drive(3, 299, 1, 12'h000);
      end
      check("pal_new", 32'({red, green, blue}), 32'hABC);

      // Pseudo-random stream around the top-left of the box.
      for (int i = 0; i < 40; i++) begin
         drive($urandom_range(0, 40), $urandom_range(295, 300), 1'($urandom_range(0, 3) != 0),
               12'($urandom));
      end

      // Reset mid-line during a flash.
      trigger = 1'b1;
      drive(3, 299, 1, 12'h000);
      drive(4, 299, 1, 12'h000);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
      check("mid_rst_hit", 32'(sprite_hit), 32'h0);
      check("mid_rst_flash", 32'(flash_active), 32'h0);
      check("mid_rst_addr", 32'(rom_address), 32'h0);
      model_reset();
      @(negedge vga_clk);
      reset_n = 1'b1;
      pal_we = 1'b1; pal_waddr = 1'b1; pal_wdata = 12'h5A5;
      drive(40, 10, 1, 12'h000);
      drive(3, 299, 1, 12'h000);
      drive(40, 10, 1, 12'h321);
      drive(40, 10, 1, 12'h000);
      check("post_rst_rgb", 32'({red, green, blue}), 32'h5A5);
      drive(40, 10, 1, 12'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
